// File: rtl/fir_line_ctrl_if.sv
// Bus bundle for fir_line_ctrl: video sync inputs, line-buffer control and
// window outputs. Define LINE_CTRL_BORDER_EN to add the edge_o border flags.
interface fir_line_ctrl_if;
    logic        dv_i;
    logic        hs_i;
    logic        vs_i;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [10:0] addr;
    logic [1:0]  top_sel;
    logic [1:0]  mid_sel;
    logic        win_valid;
    logic [10:0] col_o;
    logic [9:0]  row_o;
    logic        dv_o;
    logic        hs_o;
    logic        vs_o;
    logic        ovf_o;
`ifdef LINE_CTRL_BORDER_EN
    logic [1:0]  edge_o;
`endif

    // Controller side
    modport slave (
        input  dv_i, hs_i, vs_i,
`ifdef LINE_CTRL_BORDER_EN
        output edge_o,
`endif
        output wr_en, wr_sel, addr, top_sel, mid_sel, win_valid,
        output col_o, row_o, dv_o, hs_o, vs_o, ovf_o
    );

    // Video source / filter side
    modport master (
        output dv_i, hs_i, vs_i,
`ifdef LINE_CTRL_BORDER_EN
        input  edge_o,
`endif
        input  wr_en, wr_sel, addr, top_sel, mid_sel, win_valid,
        input  col_o, row_o, dv_o, hs_o, vs_o, ovf_o
    );
endinterface

// File: rtl/fir_line_ctrl.sv
// 3x3 FIR line-buffer controller: tracks row/column of incoming pixels,
// rotates three line buffers, flags when a full window is available and
// re-times the sync signals to the filter output.
// Optional feature macro: LINE_CTRL_BORDER_EN (adds edge_o, window on every pixel).
module fir_line_ctrl #(
    parameter int MAX_COLS = 1600,
    parameter int MAX_ROWS = 900,
    parameter int PIPE_LAT = 3
) (
    input  logic           clk,
    input  logic           rst,
    fir_line_ctrl_if.slave bus
);
    localparam int          DLY      = PIPE_LAT + 2;
    localparam logic [10:0] COL_FULL = 11'(MAX_COLS);
    localparam logic [9:0]  ROW_LAST = 10'(MAX_ROWS - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t      state_q, state_d;
    logic        dv_q, hs_q, vs_q, dvp_q, hsp_q, vsp_q;
    logic        frame_start, line_start, line_end;
    logic [10:0] col_q, col_d, col_cur;
    logic [9:0]  row_q, row_d;
    logic [1:0]  wr_sel_q, wr_sel_d;
    logic        row_sat_q, row_sat_d;
    logic        ovf_q, ovf_d;
    logic        wr_en_q, wr_en_d;
    logic [10:0] addr_q, addr_d;
    logic [9:0]  wr_row_q, wr_row_d;
    logic        wr_run_q, wr_run_d;
    logic        win_valid_q, win_valid_d;
    logic [10:0] col_o_q;
    logic [9:0]  row_o_q;
`ifdef LINE_CTRL_BORDER_EN
    logic [1:0]  edge_q;
`endif
    logic [2:0]  dly_q [DLY];
    logic [2:0]  dly_d [DLY];

    // Input registers plus one more stage for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            {dv_q, hs_q, vs_q}    <= '0;
            {dvp_q, hsp_q, vsp_q} <= '0;
        end else begin
            {dv_q, hs_q, vs_q}    <= {bus.dv_i, bus.hs_i, bus.vs_i};
            {dvp_q, hsp_q, vsp_q} <= {dv_q, hs_q, vs_q};
        end
    end

    // State, counters and write-port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            wr_sel_q  <= '0;
            row_sat_q <= 1'b0;
            ovf_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            wr_row_q  <= '0;
            wr_run_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            wr_sel_q  <= wr_sel_d;
            row_sat_q <= row_sat_d;
            ovf_q     <= ovf_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            wr_row_q  <= wr_row_d;
            wr_run_q  <= wr_run_d;
        end
    end

    // Next-state: frame start wins over everything; a line start in the same
    // cycle as a pixel makes that pixel land in column 0
    always_comb begin
        frame_start = vs_q & ~vsp_q;
        line_start  = hs_q & ~hsp_q;
        line_end    = dvp_q & ~dv_q;
        col_cur     = line_start ? 11'd0 : col_q;
        state_d     = state_q;
        col_d       = col_cur;
        row_d       = row_q;
        wr_sel_d    = wr_sel_q;
        row_sat_d   = row_sat_q;
        ovf_d       = ovf_q;
        wr_en_d     = 1'b0;
        addr_d      = addr_q;
        wr_row_d    = wr_row_q;
        wr_run_d    = wr_run_q;
        if (frame_start) begin
            state_d   = FILL;
            col_d     = '0;
            row_d     = '0;
            wr_sel_d  = '0;
            row_sat_d = 1'b0;
            ovf_d     = 1'b0;
        end else if (state_q != IDLE) begin
            if (dv_q && !row_sat_q) begin
                if (col_cur == COL_FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en_d  = 1'b1;
                    addr_d   = col_cur;
                    wr_row_d = row_q;
                    wr_run_d = (state_q == RUN);
                    col_d    = col_cur + 11'd1;
                end
            end
            if (line_end && !row_sat_q) begin
                if (row_q == ROW_LAST) begin
                    ovf_d     = 1'b1;
                    row_sat_d = 1'b1;
                end else begin
                    row_d    = row_q + 10'd1;
                    wr_sel_d = (wr_sel_q == 2'd2) ? 2'd0 : wr_sel_q + 2'd1;
                    if (state_q == FILL && row_q == 10'd1)
                        state_d = RUN;
                end
            end
        end
    end

    // Window flag one cycle after the write, matching BRAM read latency
    always_comb begin
`ifdef LINE_CTRL_BORDER_EN
        win_valid_d = wr_en_q;
`else
        win_valid_d = wr_en_q & wr_run_q & (addr_q >= 11'd2);
`endif
    end

    // Window coordinate registers, updated with each written pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid_q <= 1'b0;
            col_o_q     <= '0;
            row_o_q     <= '0;
`ifdef LINE_CTRL_BORDER_EN
            edge_q      <= '0;
`endif
        end else begin
            win_valid_q <= win_valid_d;
            if (wr_en_q) begin
                col_o_q <= addr_q;
                row_o_q <= wr_row_q;
`ifdef LINE_CTRL_BORDER_EN
                edge_q  <= {wr_row_q < 10'd2, addr_q < 11'd2};
`endif
            end
        end
    end

    // Sync delay line: stage 0 takes the raw inputs, later stages chain
    genvar gi;
    generate
        for (gi = 0; gi < DLY; gi++) begin : g_dly
            if (gi == 0) begin : g_head
                assign dly_d[gi] = {bus.dv_i, bus.hs_i, bus.vs_i};
            end else begin : g_tail
                assign dly_d[gi] = dly_q[gi-1];
            end
        end
    endgenerate

    // Delay line registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DLY; i++) dly_q[i] <= '0;
        end else begin
            for (int i = 0; i < DLY; i++) dly_q[i] <= dly_d[i];
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_sel    = wr_sel_q;
    assign bus.addr      = addr_q;
    assign bus.top_sel   = (wr_sel_q == 2'd2) ? 2'd0 : wr_sel_q + 2'd1;
    assign bus.mid_sel   = (wr_sel_q == 2'd0) ? 2'd2 : wr_sel_q - 2'd1;
    assign bus.win_valid = win_valid_q;
    assign bus.col_o     = col_o_q;
    assign bus.row_o     = row_o_q;
    assign bus.ovf_o     = ovf_q;
    assign bus.dv_o      = dly_q[DLY-1][2];
    assign bus.hs_o      = dly_q[DLY-1][1];
    assign bus.vs_o      = dly_q[DLY-1][0];
`ifdef LINE_CTRL_BORDER_EN
    assign bus.edge_o    = edge_q;
`endif
endmodule

// File: tb/tb_fir_line_ctrl.sv
// Directed bench for fir_line_ctrl (MAX_COLS=8, MAX_ROWS=6, PIPE_LAT=3).
// Border scenario runs only when LINE_CTRL_BORDER_EN is defined.
module tb_fir_line_ctrl;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    fir_line_ctrl_if bus();

    fir_line_ctrl #(.MAX_COLS(8), .MAX_ROWS(6), .PIPE_LAT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // per-line monitor state
    int         step_no;
    int         wr_cnt, win_cnt, last_wr_step, ovf_step;
    bit         ovf_seen;
    logic [1:0] first_wr_sel, first_top, first_mid;
    logic [10:0] first_win_col, last_win_col;
    logic [9:0]  first_win_row, last_win_row;
`ifdef LINE_CTRL_BORDER_EN
    logic [1:0] edge00, edge22;
`endif

    task automatic clear_mon();
        wr_cnt = 0; win_cnt = 0; ovf_seen = 0; ovf_step = -1; last_wr_step = -1;
        first_wr_sel = 'x; first_top = 'x; first_mid = 'x;
        first_win_col = 'x; first_win_row = 'x; last_win_col = 'x; last_win_row = 'x;
    endtask

    // advance one clock and sample outputs 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.wr_en === 1'b1) begin
            if (wr_cnt == 0) begin
                first_wr_sel = bus.wr_sel; first_top = bus.top_sel; first_mid = bus.mid_sel;
            end
            wr_cnt++;
            last_wr_step = step_no;
        end
        if (bus.win_valid === 1'b1) begin
            if (win_cnt == 0) begin
                first_win_col = bus.col_o; first_win_row = bus.row_o;
            end
            win_cnt++;
            last_win_col = bus.col_o; last_win_row = bus.row_o;
`ifdef LINE_CTRL_BORDER_EN
            if (bus.col_o == 0 && bus.row_o == 0) edge00 = bus.edge_o;
            if (bus.col_o == 2 && bus.row_o == 2) edge22 = bus.edge_o;
`endif
        end
        if (bus.ovf_o === 1'b1 && !ovf_seen) begin
            ovf_seen = 1; ovf_step = step_no;
        end
        step_no++;
    endtask

    task automatic vs_pulse();
        bus.vs_i = 1'b1; step();
        bus.vs_i = 1'b0; repeat (3) step();
    endtask

    task automatic send_line(input int npix, input bit vs_at_end);
        bus.hs_i = 1'b1; step();
        bus.hs_i = 1'b0; step();
        for (int k = 0; k < npix; k++) begin
            bus.dv_i = 1'b1; step();
        end
        bus.dv_i = 1'b0; bus.vs_i = vs_at_end; step();
        bus.vs_i = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; repeat (3) step();
        rst = 1'b0;
        checks++; if (bus.wr_en !== 1'b0 || bus.win_valid !== 1'b0) begin failures++;
            $display("FAIL reset_strobes wr_en=%b win_valid=%b required 0/0", bus.wr_en, bus.win_valid); end
        checks++; if (bus.addr !== 11'd0 || bus.col_o !== 11'd0 || bus.row_o !== 10'd0) begin failures++;
            $display("FAIL reset_coords addr=%0d col_o=%0d row_o=%0d required 0", bus.addr, bus.col_o, bus.row_o); end
        checks++; if (bus.wr_sel !== 2'd0 || bus.top_sel !== 2'd1 || bus.mid_sel !== 2'd2) begin failures++;
            $display("FAIL reset_sel wr/top/mid=%0d/%0d/%0d required 0/1/2", bus.wr_sel, bus.top_sel, bus.mid_sel); end
        checks++; if ({bus.dv_o, bus.hs_o, bus.vs_o, bus.ovf_o} !== 4'b0000) begin failures++;
            $display("FAIL reset_misc dv/hs/vs/ovf=%b required 0000", {bus.dv_o, bus.hs_o, bus.vs_o, bus.ovf_o}); end
    endtask

    task automatic test_idle_ignore();
        clear_mon();
        send_line(8, 1'b0);
        checks++; if (wr_cnt != 0 || win_cnt != 0) begin failures++;
            $display("FAIL idle_ignore wr=%0d win=%0d required 0/0", wr_cnt, win_cnt); end
    endtask

    task automatic test_frame();
        logic [1:0] exp_sel [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        int         exp_win [4] = '{0, 0, 6, 6};
        int         total_win = 0;
        vs_pulse();
        for (int r = 0; r < 4; r++) begin
            clear_mon();
            send_line(8, 1'b0);
            total_win += win_cnt;
            checks++; if (first_wr_sel !== exp_sel[r] || wr_cnt != 8) begin failures++;
                $display("FAIL frame_wr row=%0d wr_sel=%0d wr=%0d required %0d/8", r, first_wr_sel, wr_cnt, exp_sel[r]); end
            checks++; if (win_cnt != exp_win[r]) begin failures++;
                $display("FAIL frame_win row=%0d win=%0d required %0d", r, win_cnt, exp_win[r]); end
            if (r == 0) begin
                checks++; if (first_top !== 2'd1 || first_mid !== 2'd2) begin failures++;
                    $display("FAIL frame_sel_row0 top/mid=%0d/%0d required 1/2", first_top, first_mid); end
            end
            if (r == 2) begin
                checks++; if (first_top !== 2'd0 || first_mid !== 2'd1) begin failures++;
                    $display("FAIL frame_sel_row2 top/mid=%0d/%0d required 0/1", first_top, first_mid); end
                checks++; if (first_win_col !== 11'd2 || first_win_row !== 10'd2) begin failures++;
                    $display("FAIL frame_first_win col/row=%0d/%0d required 2/2", first_win_col, first_win_row); end
            end
            if (r == 3) begin
                checks++; if (last_win_col !== 11'd7 || last_win_row !== 10'd3) begin failures++;
                    $display("FAIL frame_last_win col/row=%0d/%0d required 7/3", last_win_col, last_win_row); end
            end
        end
        checks++; if (total_win != 12) begin failures++;
            $display("FAIL frame_win_total win=%0d required 12", total_win); end
    endtask

    task automatic test_col_overflow();
        vs_pulse();
        clear_mon();
        send_line(9, 1'b0);
        checks++; if (wr_cnt != 8) begin failures++;
            $display("FAIL colovf_wr wr=%0d required 8", wr_cnt); end
        checks++; if (!ovf_seen || ovf_step != last_wr_step + 1) begin failures++;
            $display("FAIL colovf_when ovf_step=%0d required %0d", ovf_step, last_wr_step + 1); end
        clear_mon();
        send_line(3, 1'b0);
        checks++; if (wr_cnt != 3 || bus.ovf_o !== 1'b1) begin failures++;
            $display("FAIL colovf_next_line wr=%0d ovf=%b required 3/1", wr_cnt, bus.ovf_o); end
        vs_pulse();
        checks++; if (bus.ovf_o !== 1'b0) begin failures++;
            $display("FAIL colovf_clear ovf=%b required 0", bus.ovf_o); end
    endtask

    task automatic test_row_overflow();
        vs_pulse();
        for (int r = 0; r < 6; r++) begin
            clear_mon();
            send_line(8, 1'b0);
        end
        checks++; if (wr_cnt != 8 || bus.ovf_o !== 1'b1) begin failures++;
            $display("FAIL rowovf_last wr=%0d ovf=%b required 8/1", wr_cnt, bus.ovf_o); end
        clear_mon();
        send_line(8, 1'b0);
        checks++; if (wr_cnt != 0 || win_cnt != 0) begin failures++;
            $display("FAIL rowovf_blocked wr=%0d win=%0d required 0/0", wr_cnt, win_cnt); end
    endtask

    task automatic test_frame_priority();
        vs_pulse();
        for (int r = 0; r < 3; r++) send_line(8, 1'b0);
        send_line(8, 1'b1);
        checks++; if (bus.wr_sel !== 2'd0) begin failures++;
            $display("FAIL prio_wr_sel wr_sel=%0d required 0", bus.wr_sel); end
        clear_mon();
        send_line(8, 1'b0);
        checks++; if (bus.row_o !== 10'd0 || first_wr_sel !== 2'd0 || win_cnt != 0) begin failures++;
            $display("FAIL prio_line0 row_o=%0d wr_sel=%0d win=%0d required 0/0/0", bus.row_o, first_wr_sel, win_cnt); end
        clear_mon();
        send_line(8, 1'b0);
        checks++; if (first_wr_sel !== 2'd1 || win_cnt != 0) begin failures++;
            $display("FAIL prio_line1 wr_sel=%0d win=%0d required 1/0", first_wr_sel, win_cnt); end
        clear_mon();
        send_line(8, 1'b0);
        checks++; if (win_cnt != 6) begin failures++;
            $display("FAIL prio_line2 win=%0d required 6", win_cnt); end
    endtask

    task automatic test_reset_mid();
        vs_pulse();
        for (int r = 0; r < 3; r++) send_line(8, 1'b0);
        bus.hs_i = 1'b1; step();
        bus.hs_i = 1'b0; step();
        repeat (4) begin bus.dv_i = 1'b1; step(); end
        rst = 1'b1; step();
        rst = 1'b0;
        checks++; if (bus.wr_en !== 1'b0 || bus.win_valid !== 1'b0 || bus.ovf_o !== 1'b0 ||
                      bus.addr !== 11'd0 || bus.col_o !== 11'd0 || bus.row_o !== 10'd0) begin failures++;
            $display("FAIL rstmid_outputs wr=%b win=%b ovf=%b addr=%0d col=%0d row=%0d required all 0",
                     bus.wr_en, bus.win_valid, bus.ovf_o, bus.addr, bus.col_o, bus.row_o); end
        checks++; if (bus.wr_sel !== 2'd0 || bus.top_sel !== 2'd1 || bus.mid_sel !== 2'd2 ||
                      {bus.dv_o, bus.hs_o, bus.vs_o} !== 3'b000) begin failures++;
            $display("FAIL rstmid_sel wr/top/mid=%0d/%0d/%0d sync=%b required 0/1/2 000",
                     bus.wr_sel, bus.top_sel, bus.mid_sel, {bus.dv_o, bus.hs_o, bus.vs_o}); end
        clear_mon();
        repeat (3) step();
        bus.dv_i = 1'b0; repeat (5) step();
        send_line(8, 1'b0);
        checks++; if (wr_cnt != 0 || win_cnt != 0) begin failures++;
            $display("FAIL rstmid_quiet wr=%0d win=%0d required 0/0", wr_cnt, win_cnt); end
        vs_pulse();
        clear_mon();
        send_line(8, 1'b0);
        checks++; if (wr_cnt != 8) begin failures++;
            $display("FAIL rstmid_resume wr=%0d required 8", wr_cnt); end
    endtask

    task automatic test_delay();
        logic [2:0] hist [64];
        logic [2:0] obs;
        for (int j = 0; j < 64; j++) begin
            hist[j] = 3'($urandom_range(0, 7));
            {bus.dv_i, bus.hs_i, bus.vs_i} = hist[j];
            step();
            obs = {bus.dv_o, bus.hs_o, bus.vs_o};
            if (j >= 4) begin
                checks++; if (obs !== hist[j-4]) begin failures++;
                    $display("FAIL delay_line cycle=%0d dv/hs/vs=%b required %b", j, obs, hist[j-4]); end
            end
        end
        {bus.dv_i, bus.hs_i, bus.vs_i} = 3'b000;
        repeat (6) step();
    endtask

`ifdef LINE_CTRL_BORDER_EN
    task automatic test_border();
        int total = 0;
        edge00 = 'x; edge22 = 'x;
        vs_pulse();
        for (int r = 0; r < 6; r++) begin
            clear_mon();
            send_line(8, 1'b0);
            total += win_cnt;
        end
        checks++; if (total != 48) begin failures++;
            $display("FAIL border_count win=%0d required 48", total); end
        checks++; if (edge00 !== 2'b11) begin failures++;
            $display("FAIL border_edge00 edge=%b required 11", edge00); end
        checks++; if (edge22 !== 2'b00) begin failures++;
            $display("FAIL border_edge22 edge=%b required 00", edge22); end
    endtask
`endif

    initial begin
        step_no = 0;
        rst = 1'b1;
        bus.dv_i = 1'b0; bus.hs_i = 1'b0; bus.vs_i = 1'b0;
        clear_mon();
        test_reset();
        test_idle_ignore();
        test_frame();
        test_col_overflow();
        test_row_overflow();
        test_frame_priority();
        test_reset_mid();
        test_delay();
`ifdef LINE_CTRL_BORDER_EN
        rst = 1'b1; step(); rst = 1'b0; step();
        test_border();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
